// File: rtl/updown_limit_counter.sv
// ---------------------------------------------------------------------------
// updown_limit_counter
//   Up/down counter with a run-time upper limit (MAX_VALUE) and a fixed lower
//   limit of zero. A build-time switch selects wrapping or saturating
//   behaviour at the limits. A step attempted at a limit raises a registered
//   one-cycle TRIG_OUT pulse and sets the sticky WRAPPED flag.
//
//   Ports
//     CLK         rising-edge clock
//     RESET       synchronous active-high reset, overrides everything
//     ENABLE      request one count step this cycle
//     UP          step direction (1 = up, 0 = down), used only with ENABLE
//     LOAD        synchronous parallel load, wins over ENABLE
//     LOAD_VALUE  load value, clamped to MAX_VALUE
//     MAX_VALUE   run-time upper limit
//     COUNT       registered count
//     TRIG_OUT    registered pulse: the previous cycle stepped at a limit
//     WRAPPED     sticky limit-hit flag, cleared by LOAD or RESET
//     AT_MAX      COUNT >= MAX_VALUE (combinational)
//     AT_ZERO     COUNT == 0 (combinational)
// ---------------------------------------------------------------------------
module updown_limit_counter #(
  parameter int COUNTER_WIDTH = 8,
  parameter int RESET_VALUE   = 0,
  parameter bit WRAP_MODE     = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic                     UP,
  input  logic                     LOAD,
  input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE,
  input  logic [COUNTER_WIDTH-1:0] MAX_VALUE,
  output logic [COUNTER_WIDTH-1:0] COUNT,
  output logic                     TRIG_OUT,
  output logic                     WRAPPED,
  output logic                     AT_MAX,
  output logic                     AT_ZERO
);

  localparam logic [COUNTER_WIDTH-1:0] RST_VAL = COUNTER_WIDTH'(RESET_VALUE);
  localparam logic [COUNTER_WIDTH-1:0] ZERO    = '0;

  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     trig_q, trig_d;
  logic                     wrapped_q, wrapped_d;

  // Next-state logic. Limits are checked before any +1/-1, so the
  // arithmetic can never overflow or underflow.
  always_comb begin
    count_d   = count_q;
    trig_d    = 1'b0;
    wrapped_d = wrapped_q;
    if (LOAD) begin
      count_d   = (LOAD_VALUE <= MAX_VALUE) ? LOAD_VALUE : MAX_VALUE;
      wrapped_d = 1'b0;
    end else if (ENABLE) begin
      if (UP) begin
        if (count_q < MAX_VALUE) begin
          count_d = count_q + 1'b1;
        end else begin
          trig_d    = 1'b1;
          wrapped_d = 1'b1;
          count_d   = WRAP_MODE ? ZERO : MAX_VALUE;
        end
      end else begin
        if (count_q > MAX_VALUE) begin
          // Limit was lowered under the count: snap down without a trigger.
          count_d = MAX_VALUE;
        end else if (count_q != ZERO) begin
          count_d = count_q - 1'b1;
        end else begin
          trig_d    = 1'b1;
          wrapped_d = 1'b1;
          count_d   = WRAP_MODE ? MAX_VALUE : ZERO;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q   <= RST_VAL;
      trig_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      trig_q    <= trig_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign COUNT    = count_q;
  assign TRIG_OUT = trig_q;
  assign WRAPPED  = wrapped_q;
  assign AT_MAX   = (count_q >= MAX_VALUE);
  assign AT_ZERO  = (count_q == ZERO);

endmodule

// File: tb/tb_updown_limit_counter.sv
// Two counters (wrap with RESET_VALUE=3, saturate with RESET_VALUE=0) share
// one stimulus stream. A driver pushes the model's expected state for each
// cycle into a queue; a monitor pops and compares on the falling edge.
module tb_updown_limit_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1, en = 1'b0, up = 1'b0, ld = 1'b0;
  logic [W-1:0] lv = '0, mx = 4'd9;

  logic [W-1:0] cnt_w, cnt_s;
  logic         trg_w, trg_s, wr_w, wr_s, amx_w, amx_s, az_w, az_s;

  always #5 clk = ~clk;

  updown_limit_counter #(.COUNTER_WIDTH(W), .RESET_VALUE(3), .WRAP_MODE(1'b1)) dut_w (
    .CLK(clk), .RESET(rst), .ENABLE(en), .UP(up), .LOAD(ld), .LOAD_VALUE(lv),
    .MAX_VALUE(mx), .COUNT(cnt_w), .TRIG_OUT(trg_w), .WRAPPED(wr_w),
    .AT_MAX(amx_w), .AT_ZERO(az_w));

  updown_limit_counter #(.COUNTER_WIDTH(W), .RESET_VALUE(0), .WRAP_MODE(1'b0)) dut_s (
    .CLK(clk), .RESET(rst), .ENABLE(en), .UP(up), .LOAD(ld), .LOAD_VALUE(lv),
    .MAX_VALUE(mx), .COUNT(cnt_s), .TRIG_OUT(trg_s), .WRAPPED(wr_s),
    .AT_MAX(amx_s), .AT_ZERO(az_s));

  typedef struct { int c; bit t; bit w; } st_t;
  typedef struct { st_t a; st_t b; string tag; } exp_t;

  exp_t q[$];
  st_t  mw, ms;
  int   chk_cnt = 0, pass_cnt = 0;

  // Reference behaviour written straight from the counter's rules on ints.
  function automatic st_t nxt(st_t s, bit wm, int rv, bit r, bit l, int lval,
                              bit e, bit u, int m);
    st_t n = s;
    n.t = 1'b0;
    if (r) begin
      n.c = rv; n.w = 1'b0;
    end else if (l) begin
      n.c = (lval > m) ? m : lval; n.w = 1'b0;
    end else if (e) begin
      if (u) begin
        if (s.c >= m) begin n.t = 1'b1; n.w = 1'b1; n.c = wm ? 0 : m; end
        else n.c = s.c + 1;
      end else begin
        if (s.c > m) n.c = m;
        else if (s.c == 0) begin n.t = 1'b1; n.w = 1'b1; n.c = wm ? m : 0; end
        else n.c = s.c - 1;
      end
    end
    return n;
  endfunction

  task automatic chk(string nm, string tag, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s [%s]: got %0d expected %0d", nm, tag, act, exp);
  endtask

  // Drive one cycle of inputs and record what both counters must show after it.
  task automatic step(string tag, bit r, bit l, int lval, bit e, bit u, int m);
    exp_t x;
    @(negedge clk); #1;
    rst = r; ld = l; lv = W'(lval); en = e; up = u; mx = W'(m);
    mw = nxt(mw, 1'b1, 3, r, l, lval, e, u, m);
    ms = nxt(ms, 1'b0, 0, r, l, lval, e, u, m);
    x.a = mw; x.b = ms; x.tag = tag;
    q.push_back(x);
  endtask

  // Monitor: the counters present a new state every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wrap_count",     e.tag, int'(cnt_w), e.a.c);
      chk("wrap_trig",      e.tag, int'(trg_w), int'(e.a.t));
      chk("wrap_wrapped",   e.tag, int'(wr_w),  int'(e.a.w));
      chk("wrap_at_max",    e.tag, int'(amx_w), int'(e.a.c >= int'(mx)));
      chk("wrap_at_zero",   e.tag, int'(az_w),  int'(e.a.c == 0));
      chk("sat_count",      e.tag, int'(cnt_s), e.b.c);
      chk("sat_trig",       e.tag, int'(trg_s), int'(e.b.t));
      chk("sat_wrapped",    e.tag, int'(wr_s),  int'(e.b.w));
      chk("sat_at_max",     e.tag, int'(amx_s), int'(e.b.c >= int'(mx)));
      chk("sat_at_zero",    e.tag, int'(az_s),  int'(e.b.c == 0));
    end
  end

  initial begin
    mw = '{c: 0, t: 1'b0, w: 1'b0};
    ms = '{c: 0, t: 1'b0, w: 1'b0};

    step("reset", 1, 0, 0, 0, 0, 9);
    step("reset2", 1, 0, 0, 1, 1, 9);

    // Count up from 0 through the limit.
    step("load0", 0, 1, 0, 0, 0, 9);
    for (int i = 0; i < 10; i++) step("up_wrap", 0, 0, 0, 1, 1, 9);
    step("hold", 0, 0, 0, 0, 1, 9);

    // Count down from 0.
    step("load0b", 0, 1, 0, 0, 0, 9);
    for (int i = 0; i < 3; i++) step("down_wrap", 0, 0, 0, 1, 0, 9);

    // Saturate case: 12 up steps from 0.
    step("load0c", 0, 1, 0, 0, 0, 9);
    for (int i = 0; i < 12; i++) step("up_sat", 0, 0, 0, 1, 1, 9);

    // Load clamp with a simultaneous step, then an in-range load.
    step("load_clamp", 0, 1, 13, 1, 1, 9);
    step("load4", 0, 1, 4, 0, 0, 9);

    // Limit lowered below the count.
    step("load7", 0, 1, 7, 0, 0, 9);
    step("lower_up", 0, 0, 0, 1, 1, 5);
    step("load7b", 0, 1, 7, 0, 0, 9);
    step("lower_down", 0, 0, 0, 1, 0, 5);

    // Reset while loading and stepping.
    step("load8", 0, 1, 8, 0, 0, 9);
    step("rst_mid", 1, 1, 2, 1, 1, 9);
    step("after_rst", 0, 0, 0, 0, 0, 9);

    // Zero limit: every enabled step hits.
    step("load0d", 0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("max0", 0, 0, 0, 1, int'($urandom_range(0, 1)), 0);

    // Boundary: full-scale limit.
    step("load14", 0, 1, 14, 0, 0, 15);
    for (int i = 0; i < 3; i++) step("max15", 0, 0, 0, 1, 1, 15);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 9);
    end

    step("idle", 0, 0, 0, 0, 0, 9);
    repeat (3) @(negedge clk);
    #2;
    chk("queue_drained", "end", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
